serial_adder: RTL and testbench

- Bit-serial N-bit adder: the addition counterpart of the team's combinational full subtractor.
- Accepts two operands and a carry-in through a valid/ready handshake.
- Adds the operands LSB-first, one bit per clock, through a single registered full-adder cell.
- Returns sum, carry-out and signed overflow through a valid/ready handshake.
- Used in area-constrained datapaths where a WIDTH-bit ripple adder is too costly.

---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/full_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 142 ++++++++++++++
 tb/tb_serial_adder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and defaults for the bit-serial adder
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } serial_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - one-bit combinational full adder
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder with valid/ready operand and result handshakes
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

    if (WIDTH < 2) begin : g_width_check
        $error("serial_adder: WIDTH must be at least 2");
    end

    serial_state_t    state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    // The final bit goes straight into sum, so the partial-sum register is one bit short.
    logic [WIDTH-2:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic             c_msb_q, c_msb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_next;

    full_adder_cell u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign sum_next = {fa_s, sum_sr_q};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        c_msb_d  = c_msb_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    carry_d  = cin;
                    cnt_d    = '0;
                    sum_sr_d = '0;
                    state_d  = SHIFT;
                end
            end

            SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = sum_next[WIDTH-1:1];
                carry_d  = fa_c;
                // Carry leaving bit WIDTH-2 is the carry into the sign bit.
                if (cnt_q == CNT_PENULT) begin
                    c_msb_d = fa_c;
                end
                if (cnt_q == CNT_LAST) begin
                    sum_d   = sum_next;
                    cout_d  = fa_c;
                    ovf_d   = c_msb_q ^ fa_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            c_msb_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            c_msb_q  <= c_msb_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and random self-checking bench for serial_adder
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;
    int n_out    = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always @(posedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) n_acc++;
            if (out_valid && out_ready) n_out++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE, optionally stall the result and scramble inputs in flight.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input int stall, input bit toggle,
                          output logic [7:0] rs, output logic rc, output logic ro,
                          output int lat);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_v;
        cin       = tc;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (toggle) begin
                a        = ~a;
                b        = 8'($urandom_range(0, 255));
                cin      = ~cin;
                in_valid = ~in_valid;
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        rs = sum;
        rc = cout;
        ro = ovf;
        for (int k = 0; k < stall; k++) begin
            tick();
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_result", 32'({ovf, cout, sum}), 32'({ro, rc, rs}));
        end
        out_ready = 1'b1;
        tick();
        check("handoff_out_valid", 32'(out_valid), 32'd0);
    endtask

    logic [7:0] da [5] = '{8'h3C, 8'hFF, 8'h00, 8'h7F, 8'h80};
    logic [7:0] db [5] = '{8'h05, 8'h01, 8'h00, 8'h01, 8'h80};
    logic       dc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] es [5] = '{8'h41, 8'h00, 8'h01, 8'h80, 8'h00};
    logic       ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] rs;
        logic       rc;
        logic       ro;
        int         lat;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rci;
        logic [8:0] exp9;
        logic       exp_ovf;
        int         base_acc;
        int         base_out;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        tick();
        tick();
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'({ovf, cout, sum}), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_op(da[i], db[i], dc[i], 0, 1'b0, rs, rc, ro, lat);
            check($sformatf("dir%0d_sum", i), 32'(rs), 32'(es[i]));
            check($sformatf("dir%0d_cout", i), 32'(rc), 32'(ec[i]));
            check($sformatf("dir%0d_ovf", i), 32'(ro), 32'(eo[i]));
            check($sformatf("dir%0d_latency", i), 32'(lat), 32'd8);
        end

        // 0x55 + 0x2A + 1 = 0x80: positive operands, negative sum
        run_op(8'h55, 8'h2A, 1'b1, 5, 1'b1, rs, rc, ro, lat);
        check("bp_sum", 32'(rs), 32'h80);
        check("bp_cout", 32'(rc), 32'd0);
        check("bp_ovf", 32'(ro), 32'd1);
        check("bp_latency", 32'(lat), 32'd8);

        in_valid = 1'b1;
        a        = 8'h12;
        b        = 8'h34;
        cin      = 1'b0;
        tick();
        in_valid = 1'b0;
        check("abort_busy", 32'(in_ready), 32'd0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", 32'({ovf, cout, sum}), 32'd0);
        run_op(8'h12, 8'h34, 1'b0, 0, 1'b0, rs, rc, ro, lat);
        check("abort_redo_sum", 32'(rs), 32'h46);
        check("abort_redo_flags", 32'({ro, rc}), 32'd0);

        base_acc = n_acc;
        base_out = n_out;
        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rci  = 1'($urandom_range(0, 1));
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rci};
            exp_ovf = (ra[7] == rb[7]) && (exp9[7] != ra[7]);
            run_op(ra, rb, rci, $urandom_range(0, 3), 1'($urandom_range(0, 1)), rs, rc, ro, lat);
            check($sformatf("rnd%0d_sum", i), 32'({rc, rs}), 32'(exp9));
            check($sformatf("rnd%0d_ovf", i), 32'(ro), 32'(exp_ovf));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd8);
        end
        check("rnd_accepted", 32'(n_acc - base_acc), 32'd1000);
        check("rnd_delivered", 32'(n_out - base_out), 32'd1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
